// File: rtl/cell_redraw_scheduler_pkg.sv
// Shared types and sizing for the Sudoku cell redraw scheduler.
package screen;
  localparam int GRID_N     = 9;
  localparam int CELL_COUNT = GRID_N * GRID_N;

  typedef enum logic [1:0] {SCAN, ISSUE, WAIT} sched_state;
endpackage

// File: rtl/cell_redraw_scheduler_if.sv
// Scheduler-to-renderer handshake bundle. With CURSOR_HL_EN the bundle carries cell_highlight.
interface cell_redraw_scheduler_if #(parameter int DATA_W = 4);
  logic              cell_start;
  logic [3:0]        cell_row;
  logic [3:0]        cell_col;
  logic [DATA_W-1:0] cell_data;
  logic              busy;
  logic              cell_done;
`ifdef CURSOR_HL_EN
  logic              cell_highlight;
`endif

  modport master (
    output cell_start, cell_row, cell_col, cell_data, busy,
`ifdef CURSOR_HL_EN
    output cell_highlight,
`endif
    input  cell_done
  );

  modport slave (
    input  cell_start, cell_row, cell_col, cell_data, busy,
`ifdef CURSOR_HL_EN
    input  cell_highlight,
`endif
    output cell_done
  );
endinterface

// File: rtl/cell_redraw_scheduler_grid_scan_ptr.sv
// Row-major scan pointer over the grid; wrap pulses on the (N-1,N-1) -> (0,0) step.
module grid_scan_ptr #(
  parameter int GRID_N = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       wrap
);
  logic last_col;
  logic last_row;

  assign last_col = (col == 4'(GRID_N - 1));
  assign last_row = (row == 4'(GRID_N - 1));
  assign wrap     = advance && last_col && last_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      row <= 4'd0;
      col <= 4'd0;
    end else if (advance) begin
      if (last_col) begin
        col <= 4'd0;
        row <= last_row ? 4'd0 : row + 4'd1;
      end else begin
        col <= col + 4'd1;
      end
    end
  end
endmodule

// File: rtl/cell_redraw_scheduler.sv
// Sweeps the grid and issues only changed or forced cells to the renderer, one at a time.
// Optional cursor highlighting is compiled in with CURSOR_HL_EN.
module cell_redraw_scheduler
  import screen::*;
#(
  parameter int GRID_N = 9,
  parameter int DATA_W = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [GRID_N-1:0][GRID_N-1:0][DATA_W-1:0] display_grid,
  input  logic                                     full_refresh,
  input  logic                                     draw_enable,
`ifdef CURSOR_HL_EN
  input  logic [3:0]                               cursor_row,
  input  logic [3:0]                               cursor_col,
`endif
  cell_redraw_scheduler_if.master                  rnd,
  output logic                                     synced
);
  sched_state        state;
  logic [DATA_W-1:0] shadow     [GRID_N][GRID_N];
  logic              force_bits [GRID_N][GRID_N];
  logic              pass_issued;
  logic [3:0]        ptr_row;
  logic [3:0]        ptr_col;
  logic              ptr_wrap;
  logic              advance;
  logic              need_draw;
  logic [DATA_W-1:0] cur_val;
`ifdef CURSOR_HL_EN
  logic [3:0]        cursor_row_prev;
  logic [3:0]        cursor_col_prev;
`endif

  always_comb begin
    cur_val   = display_grid[ptr_row][ptr_col];
    need_draw = force_bits[ptr_row][ptr_col] || (cur_val != shadow[ptr_row][ptr_col]);
    advance   = ((state == SCAN) && draw_enable && !need_draw) ||
                ((state == WAIT) && rnd.cell_done);
  end

  grid_scan_ptr #(.GRID_N(GRID_N)) u_ptr (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .row     (ptr_row),
    .col     (ptr_col),
    .wrap    (ptr_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SCAN;
      rnd.cell_start <= 1'b0;
      rnd.busy       <= 1'b0;
      rnd.cell_row   <= 4'd0;
      rnd.cell_col   <= 4'd0;
      rnd.cell_data  <= '0;
      synced         <= 1'b0;
      pass_issued    <= 1'b0;
      for (int r = 0; r < GRID_N; r++) begin
        for (int c = 0; c < GRID_N; c++) begin
          shadow[r][c]     <= '0;
          force_bits[r][c] <= 1'b1;
        end
      end
`ifdef CURSOR_HL_EN
      rnd.cell_highlight <= 1'b0;
      cursor_row_prev    <= 4'd0;
      cursor_col_prev    <= 4'd0;
`endif
    end else begin
      case (state)
        SCAN: begin
          if (draw_enable && need_draw) begin
            rnd.cell_row                 <= ptr_row;
            rnd.cell_col                 <= ptr_col;
            rnd.cell_data                <= cur_val;
            shadow[ptr_row][ptr_col]     <= cur_val;
            force_bits[ptr_row][ptr_col] <= 1'b0;
            rnd.cell_start               <= 1'b1;
            rnd.busy                     <= 1'b1;
            synced                       <= 1'b0;
            pass_issued                  <= 1'b1;
`ifdef CURSOR_HL_EN
            rnd.cell_highlight <= (ptr_row == cursor_row) && (ptr_col == cursor_col);
`endif
            state <= ISSUE;
          end
        end
        ISSUE: begin
          rnd.cell_start <= 1'b0;
          state          <= WAIT;
        end
        WAIT: begin
          if (rnd.cell_done) begin
            rnd.busy <= 1'b0;
            state    <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase

      // An issue never coincides with a wrap, so pass_issued reflects the finished pass.
      if (ptr_wrap) begin
        if (!pass_issued) synced <= 1'b1;
        pass_issued <= 1'b0;
      end

`ifdef CURSOR_HL_EN
      if ((cursor_row != cursor_row_prev) || (cursor_col != cursor_col_prev)) begin
        force_bits[cursor_row_prev][cursor_col_prev] <= 1'b1;
        force_bits[cursor_row][cursor_col]           <= 1'b1;
      end
      cursor_row_prev <= cursor_row;
      cursor_col_prev <= cursor_col;
`endif

      // Placed last so a refresh overrides a same-cycle force clear on the issued cell.
      if (full_refresh) begin
        for (int r = 0; r < GRID_N; r++) begin
          for (int c = 0; c < GRID_N; c++) begin
            force_bits[r][c] <= 1'b1;
          end
        end
        synced <= 1'b0;
      end
    end
  end
endmodule

// File: doc/cell_redraw_scheduler.md
# cell_redraw_scheduler

Sequences the cell renderer over the 9x9 Sudoku display grid, redrawing only cells whose value changed since they were last drawn or that were forced dirty. It sits between the game logic's `display_grid` and the per-cell renderer. It runs a continuous row-major sweep and hands out one cell at a time over a start/done handshake, so the renderer is never overrun.

## Interface
Parameters:
- `GRID_N`, default 9: cells per row/column.
- `DATA_W`, default 4: bits per cell value.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `display_grid`  in  DATA_W x GRID_N x GRID_N  current board values, indexed [row][col].
- `full_refresh`  in  1  one-cycle pulse; marks all 81 cells dirty.
- `draw_enable`  in  1  level; when low, no new cell is issued.
- `cell_done`  in  1  renderer finished the issued cell.
- `cell_start`  out  1  one-cycle pulse; renderer begins drawing.
- `cell_row`, `cell_col`  out  4  coordinates of the issued cell; stable from `cell_start` until `cell_done`.
- `cell_data`  out  DATA_W  value of the issued cell, latched at issue.
- `busy`  out  1  high from `cell_start` through the cycle `cell_done` is accepted.
- `synced`  out  1  high after a full 81-cell pass issues nothing.

## Operation
- State per cell: `shadow[r][c]` (last drawn value) and `force[r][c]` (dirty bit).
- Needs-draw(p) = `force[p]` OR (`display_grid[p]` != `shadow[p]`).
- Scan pointer (row, col) walks row-major from (0,0) to (8,8), then wraps to (0,0).
- States:
  - SCAN
    - If `draw_enable` is low, hold the pointer.
    - Else if needs-draw(ptr): latch row, col and `display_grid[ptr]` onto outputs, write `shadow[ptr]` with that value, clear `force[ptr]`, and go to ISSUE.
    - Else advance the pointer.
  - ISSUE: `cell_start`=1 and `busy`=1; go to WAIT.
  - WAIT: `busy`=1. On `cell_done`, advance the pointer and go to SCAN.
- `cell_done` is ignored outside WAIT, including in the ISSUE cycle.
- `full_refresh` sets every `force` bit and clears `synced`. If it coincides with a force-clear on the same cell, the set wins.
- A cell that changes while it is being drawn mismatches `shadow` and is redrawn on the next pass.
- `synced` is set when the pointer wraps after a pass with zero issues. It is cleared on any issue or on `full_refresh`.

## Timing
- Reset values:
  - state SCAN, pointer (0,0).
  - `cell_start`=0, `busy`=0, `synced`=0, `cell_row`=`cell_col`=0, `cell_data`=0.
  - all `shadow`=0, all `force`=1, so the first pass is a full redraw.
- Reset mid-draw aborts immediately; `cell_start` and `busy` are low the following cycle.
- Dirty cell found in SCAN at cycle T: outputs valid and `cell_start`=1 at T+1; WAIT from T+2.
- `cell_done` at cycle D: `busy`=0 and SCAN at D+1, pointer at the next cell.
- Minimum per-cell cost is 3 cycles plus renderer latency.
- A clean cell costs 1 cycle, so a fully clean sweep takes 81 cycles.
- Wrap: pointer (8,8) advances to (0,0) in one step. The pass-clean check is evaluated on that step.

## Configuration
- `CURSOR_HL_EN` defined:
  - Adds ports `cursor_row`, `cursor_col` (in, 4) and `cell_highlight` (out, 1).
  - `cell_highlight` is latched at issue: 1 when the issued cell equals the cursor.
  - A cursor change sets `force` on both the old and the new cursor cell in the same cycle.
  - Reset value of `cell_highlight` is 0.
- `CURSOR_HL_EN` undefined: these ports and their logic are absent, and behaviour is otherwise identical.

## Structure
- Package `screen` gains:
  - enum `sched_state` {SCAN, ISSUE, WAIT};
  - constants `GRID_N`=9 and `CELL_COUNT`=81.
- Sub-module `grid_scan_ptr`: row/col wrap counter with `advance` input and `wrap` output pulse.
- `shadow` and `force` arrays stay in the top module.

## Test plan
- Reset then `draw_enable`=1, all cells 0, renderer answers done 2 cycles after start -> exactly 81 `cell_start` pulses in row-major order, then `synced`=1.
- After `synced`, set `display_grid[4][7]`=5 -> single issue with row=4, col=7, data=5; `synced` drops, then re-asserts after the next clean pass.
- Change cell (2,2) to 9 while it is in WAIT with data=3 -> cell (2,2) is issued again on the next pass with data=9.
- `full_refresh` pulse mid-sweep at pointer (3,0) -> all 81 cells are redrawn, including (0,0)-(2,8) after the wrap.
- `draw_enable`=0 for 20 cycles while a cell is dirty -> no `cell_start`; issue occurs 1 cycle after re-enable. Spurious `cell_done` in SCAN/ISSUE is ignored.
- Reset asserted during WAIT -> next cycle `busy`=0 and `cell_start`=0, then a full redraw from (0,0). With `CURSOR_HL_EN`, moving the cursor (1,1)->(1,2) issues exactly those two cells, with `cell_highlight`=0 and 1 respectively.
